// File: rtl/hs_tx_sequencer.sv
// hs_tx_sequencer
//   Byte-clock controller for one high-speed transmit burst on a lane fed by
//   an 8-to-2 DDR serializer. The burst sequence is
//   LP-01 request, LP-00 prepare, HS-zero, sync byte, payload, trailer,
//   LP-11 exit. Every byte goes out on TxByteHS; the upstream source is paced
//   with TxRequestHS/TxReadyHS.
//
//   Optional feature macro: HS_TX_TIMEOUT_EN
//     defined   : payload bytes are counted and a burst is truncated after
//                 MAX_BURST bytes; TxErrTimeout pulses on the first trailer cycle
//     undefined : bursts are unbounded, TxErrTimeout is tied low
//
//   Ports
//     TxByteClk    in   byte clock (same as the serializer byte clock)
//     Tx_RST       in   asynchronous active-low reset
//     TxRequestHS  in   upstream request/valid, held for the whole burst
//     TxDataHS     in   payload byte, valid while TxRequestHS is high
//     TxReadyHS    out  byte accepted on an edge where TxRequestHS && TxReadyHS
//     TxByteHS     out  byte to the serializer parallel input
//     HsEn         out  serializer / HS driver enable
//     LpDrive      out  LP line state {Dp,Dn}
//     Busy         out  high whenever the sequencer is not idle
//     TxErrTimeout out  one-cycle truncation pulse
module hs_tx_sequencer #(
  parameter int             W         = 8,
  parameter int             T_LPX     = 2,
  parameter int             T_PREP    = 4,
  parameter int             T_ZERO    = 6,
  parameter int             T_TRAIL   = 4,
  parameter int             T_EXIT    = 3,
  parameter logic [W-1:0]   SYNC      = W'(8'hB8),
  parameter int             MAX_BURST = 1024
) (
  input  logic         TxByteClk,
  input  logic         Tx_RST,
  input  logic         TxRequestHS,
  input  logic [W-1:0] TxDataHS,
  output logic         TxReadyHS,
  output logic [W-1:0] TxByteHS,
  output logic         HsEn,
  output logic [1:0]   LpDrive,
  output logic         Busy,
  output logic         TxErrTimeout
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = imax(imax(imax(T_LPX, T_PREP), imax(T_ZERO, T_TRAIL)), T_EXIT);
  localparam int CW   = $clog2(TMAX + 1);

  // Counter is loaded with T-1 on entry so a state lasts exactly T cycles.
  localparam logic [CW-1:0] L_LPX   = CW'(T_LPX - 1);
  localparam logic [CW-1:0] L_PREP  = CW'(T_PREP - 1);
  localparam logic [CW-1:0] L_ZERO  = CW'(T_ZERO - 1);
  localparam logic [CW-1:0] L_TRAIL = CW'(T_TRAIL - 1);
  localparam logic [CW-1:0] L_EXIT  = CW'(T_EXIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_PREP, ST_ZERO, ST_SYNC, ST_DATA, ST_TRAIL, ST_EXIT
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    byte_q;
  logic            hs_q;
  logic [1:0]      lp_q;
  logic            rdy_q;
  logic            accept;
  logic            hit;      // the accepted byte is the last one allowed
  logic [W-1:0]    trail_byte;

  assign accept = TxRequestHS && rdy_q;

  // byte_q still holds the last byte sent; its MSB is the last bit on the wire.
  assign trail_byte = {W{~byte_q[W-1]}};

`ifdef HS_TX_TIMEOUT_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [BW-1:0] nacc_q;
  logic          err_q;

  assign hit = accept && (nacc_q == BW'(MAX_BURST - 1));

  // Inside DATA ready is only low after a truncation, so DATA with ready low
  // is exactly the cycle before a truncated trailer starts.
  always_ff @(posedge TxByteClk or negedge Tx_RST) begin
    if (!Tx_RST) begin
      nacc_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) nacc_q <= '0;
      else if (accept)        nacc_q <= nacc_q + BW'(1);
      err_q <= (state_q == ST_DATA) && !rdy_q;
    end
  end

  assign TxErrTimeout = err_q;
`else
  logic unused_cfg;
  assign unused_cfg   = (MAX_BURST == 0);
  assign hit          = 1'b0;
  assign TxErrTimeout = 1'b0;
`endif

  // Outputs are registered alongside the state: each transition loads the
  // output values of the state being entered.
  always_ff @(posedge TxByteClk or negedge Tx_RST) begin
    if (!Tx_RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      hs_q    <= 1'b0;
      lp_q    <= 2'b11;
      rdy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (TxRequestHS) begin
            state_q <= ST_REQ;
            cnt_q   <= L_LPX;
            lp_q    <= 2'b01;
          end
        end
        ST_REQ: begin
          if (cnt_q == '0) begin
            state_q <= ST_PREP;
            cnt_q   <= L_PREP;
            lp_q    <= 2'b00;
          end else cnt_q <= cnt_q - CW'(1);
        end
        ST_PREP: begin
          if (cnt_q == '0) begin
            state_q <= ST_ZERO;
            cnt_q   <= L_ZERO;
            hs_q    <= 1'b1;
            byte_q  <= '0;
          end else cnt_q <= cnt_q - CW'(1);
        end
        ST_ZERO: begin
          if (cnt_q == '0) begin
            state_q <= ST_SYNC;
            byte_q  <= SYNC;
            rdy_q   <= 1'b1;
          end else cnt_q <= cnt_q - CW'(1);
        end
        // SYNC and DATA share the accept path: an accepted byte goes out next
        // cycle; no accept (request dropped, or truncated) starts the trailer.
        ST_SYNC, ST_DATA: begin
          if (accept) begin
            state_q <= ST_DATA;
            byte_q  <= TxDataHS;
            if (hit) rdy_q <= 1'b0;
          end else begin
            state_q <= ST_TRAIL;
            cnt_q   <= L_TRAIL;
            byte_q  <= trail_byte;
            rdy_q   <= 1'b0;
          end
        end
        ST_TRAIL: begin
          if (cnt_q == '0) begin
            state_q <= ST_EXIT;
            cnt_q   <= L_EXIT;
            hs_q    <= 1'b0;
            lp_q    <= 2'b11;
            byte_q  <= '0;
          end else cnt_q <= cnt_q - CW'(1);
        end
        ST_EXIT: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign TxReadyHS = rdy_q;
  assign TxByteHS  = byte_q;
  assign HsEn      = hs_q;
  assign LpDrive   = lp_q;
  assign Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hs_tx_sequencer.sv
// Bench for hs_tx_sequencer: each burst is described by its payload length,
// idle gap and request-drop point; the expected per-cycle outputs come from a
// timeline model indexed by cycle number after the request is sampled.
module tb_hs_tx_sequencer;

  localparam int          P_LPX   = 2;
  localparam int          P_PREP  = 4;
  localparam int          P_ZERO  = 6;
  localparam int          P_TRAIL = 4;
  localparam int          P_EXIT  = 3;
  localparam logic [7:0]  P_SYNC  = 8'hB8;
  localparam int          MAXB    = 3;
  localparam int          S       = P_LPX + P_PREP + P_ZERO + 1;  // sync cycle

  typedef struct packed {
    logic [7:0] b;
    logic       hs;
    logic [1:0] lp;
    logic       rdy;
    logic       busy;
    logic       err;
  } obs_t;

  typedef logic [7:0] pay_t [8];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [7:0] din = 8'h00;
  logic       TxReadyHS, HsEn, Busy, TxErrTimeout;
  logic [7:0] TxByteHS;
  logic [1:0] LpDrive;

  obs_t exp_o;
  bit   chk_en = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  hs_tx_sequencer #(
    .W(8), .T_LPX(P_LPX), .T_PREP(P_PREP), .T_ZERO(P_ZERO),
    .T_TRAIL(P_TRAIL), .T_EXIT(P_EXIT), .SYNC(P_SYNC), .MAX_BURST(MAXB)
  ) dut (
    .TxByteClk(clk), .Tx_RST(rst_n), .TxRequestHS(req), .TxDataHS(din),
    .TxReadyHS(TxReadyHS), .TxByteHS(TxByteHS), .HsEn(HsEn),
    .LpDrive(LpDrive), .Busy(Busy), .TxErrTimeout(TxErrTimeout)
  );

  // Expected outputs during cycle k of a burst that carries m payload bytes
  // (k=0 is the idle cycle whose closing edge samples the request).
  function automatic obs_t model(input int k, input int m, input bit trunc, input pay_t d);
    obs_t       o;
    int         e, t, x;
    logic [7:0] last;
    o = '{b: 8'h00, hs: 1'b0, lp: 2'b11, rdy: 1'b0, busy: 1'b0, err: 1'b0};
    e = S + m;
    t = e + P_TRAIL;
    x = t + P_EXIT;
    if (m > 0) last = d[m-1];
    else       last = P_SYNC;
    if (k < 1 || k > x) return o;
    o.busy = 1'b1;
    if (k <= P_LPX) o.lp = 2'b01;
    else begin
      o.lp = 2'b00;
      if (k > P_LPX + P_PREP) o.hs = 1'b1;
      if (k == S) begin
        o.b = P_SYNC; o.rdy = 1'b1;
      end else if (k > S && k <= e) begin
        o.b = d[k-S-1]; o.rdy = !(trunc && k == e);
      end else if (k > e && k <= t) begin
        o.b = {8{~last[7]}}; o.err = trunc && (k == e + 1);
      end else if (k > t) begin
        o.lp = 2'b11; o.hs = 1'b0;
      end
    end
    return o;
  endfunction

  task automatic pin(input string nm, input logic [15:0] a, input logic [15:0] w);
    vecs++;
    if (a !== w) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, a, w);
    end
  endtask

  // Compare process: hand-computed pins of the model, then per-cycle checks.
  initial begin
    pay_t da, dm;
    obs_t act;
    for (int i = 0; i < 8; i++) begin da[i] = 8'h00; dm[i] = 8'h00; end
    da[0] = 8'hAB;
    dm[0] = 8'h01; dm[1] = 8'h02; dm[2] = 8'h03; dm[3] = 8'h7F;
    pin("lp_req_c2",     16'(model(2, 1, 1'b0, da).lp), 16'h0001);
    pin("lp_prep_c3",    16'(model(3, 1, 1'b0, da).lp), 16'h0000);
    pin("hs_rise_c7",    16'({model(6, 1, 1'b0, da).hs, model(7, 1, 1'b0, da).hs}), 16'h0001);
    pin("sync_c13",      16'({model(13, 1, 1'b0, da).b, model(13, 1, 1'b0, da).rdy}), 16'h0171);
    pin("single_c14",    16'(model(14, 1, 1'b0, da).b), 16'h00AB);
    pin("single_trail",  16'(model(15, 1, 1'b0, da).b), 16'h0000);
    pin("single_exit",   16'({model(19, 1, 1'b0, da).hs, model(19, 1, 1'b0, da).lp}), 16'h0003);
    pin("single_idle",   16'(model(22, 1, 1'b0, da).busy), 16'h0000);
    pin("multi_c17",     16'(model(17, 4, 1'b0, dm).b), 16'h007F);
    pin("multi_trail",   16'({model(18, 4, 1'b0, dm).b, model(21, 4, 1'b0, dm).b}), 16'hFFFF);
    pin("multi_exit",    16'(model(22, 4, 1'b0, dm).hs), 16'h0000);
    pin("zero_trail",    16'({model(14, 0, 1'b0, da).b, model(14, 0, 1'b0, da).hs}), 16'h0001);
    pin("zero_exit",     16'(model(18, 0, 1'b0, da).hs), 16'h0000);
    pin("trunc_rdy",     16'(model(16, 3, 1'b1, dm).rdy), 16'h0000);
    pin("trunc_err",     16'({model(17, 3, 1'b1, dm).err, model(18, 3, 1'b1, dm).err}), 16'h0002);
    forever begin
      @(negedge clk);
      if (chk_en) begin
        act = {TxByteHS, HsEn, LpDrive, TxReadyHS, Busy, TxErrTimeout};
        vecs++;
        if (act !== exp_o) begin
          errs++;
          $display("FAIL cycle t=%0t: got byte=%h hs=%b lp=%b rdy=%b busy=%b err=%b, want byte=%h hs=%b lp=%b rdy=%b busy=%b err=%b",
                   $time, act.b, act.hs, act.lp, act.rdy, act.busy, act.err,
                   exp_o.b, exp_o.hs, exp_o.lp, exp_o.rdy, exp_o.busy, exp_o.err);
        end
      end
    end
  end

  // One burst: n payload bytes, gap idle cycles first, request drop cycle for
  // zero-length bursts, request held during exit if early, optional reset at
  // cycle rst_at (negative = none).
  task automatic run_burst(input int n, input int gap, input int drop,
                           input bit early, input int rst_at, input pay_t d);
    int   m, e, t, x;
    bit   trunc, r;
    obs_t idle;
    trunc = 1'b0;
    m = n;
`ifdef HS_TX_TIMEOUT_EN
    if (n >= MAXB) begin trunc = 1'b1; m = MAXB; end
`endif
    e = S + m;
    t = e + P_TRAIL;
    x = t + P_EXIT;
    idle = model(0, m, trunc, d);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      req = 1'b0; din = 8'($urandom); exp_o = idle;
    end
    for (int k = 0; k <= x; k++) begin
      if (n == 0) r = (k < drop);
      else        r = (k < S + n) && (k <= e);
      if (k > t)  r = early;
      @(posedge clk); #1;
      if (k == rst_at) begin
        rst_n = 1'b0; req = 1'b0; exp_o = idle;
        @(negedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      req = r;
      if (k >= S && k < S + n) din = d[k-S];
      else                     din = 8'($urandom);
      exp_o = model(k, m, trunc, d);
    end
  endtask

  initial begin
    pay_t d;
    int   n, rs;
    exp_o = '{b: 8'h00, hs: 1'b0, lp: 2'b11, rdy: 1'b0, busy: 1'b0, err: 1'b0};
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    d[0] = 8'hAB;
    run_burst(1, 3, 0, 1'b0, -1, d);                  // single byte
    d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03; d[3] = 8'h7F;
    run_burst(4, 0, 0, 1'b1, -1, d);                  // multi-byte, req during exit
    run_burst(0, 0, 4, 1'b0, -1, d);                  // zero-length, late drop
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
    run_burst(5, 1, 0, 1'b0, S + 2, d);               // reset mid-DATA
    run_burst(2, 0, 0, 1'b0, -1, d);                  // full sequence after reset
    run_burst(6, 1, 0, 1'b0, -1, d);                  // continuous request

    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      n  = $urandom_range(0, 6);
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, S + 3)) : -1;
      run_burst(n, $urandom_range(0, 3), $urandom_range(1, S),
                $urandom_range(0, 3) == 0, rs, d);
    end

    repeat (2) begin
      @(posedge clk); #1;
      req = 1'b0;
      exp_o = '{b: 8'h00, hs: 1'b0, lp: 2'b11, rdy: 1'b0, busy: 1'b0, err: 1'b0};
    end
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hs_tx_sequencer.md
# hs_tx_sequencer

Byte-clock-domain controller that sequences one high-speed transmit burst on a lane driven by the SER8x2 8-to-2 DDR serializer. It arbitrates the lane between low-power (LP) signalling and HS mode. In HS mode it runs the fixed sequence: request → prepare → HS-zero → sync byte → payload → trailer → exit. It presents every byte to the serializer's parallel input (TxByteHS) and paces the upstream byte source with a ready/request handshake.

## Interface
- W, 8: byte width; must match the serializer.
- T_LPX, 2: TxByteClk cycles spent in LP-01 (HS request).
- T_PREP, 4: cycles in LP-00 (HS prepare).
- T_ZERO, 6: cycles of HS-0 (0x00) before sync.
- T_TRAIL, 4: trailer cycles.
- T_EXIT, 3: LP-11 cycles before the block returns to idle.
- SYNC, 8'hB8: sync byte.
- MAX_BURST, 1024: payload byte limit (only with HS_TX_TIMEOUT_EN).

Ports:
- TxByteClk  in  1  byte clock; same clock as the serializer's byte clock.
- Tx_RST  in  1  asynchronous active-low reset.
- TxRequestHS  in  1  upstream request/valid; held high for the whole burst.
- TxDataHS  in  W  payload byte; valid while TxRequestHS is high.
- TxReadyHS  out  1  registered; byte accepted on an edge where TxRequestHS && TxReadyHS.
- TxByteHS  out  W  registered byte to the serializer.
- HsEn  out  1  registered serializer/HS driver enable.
- LpDrive  out  2  registered LP line state {Dp,Dn}.
- Busy  out  1  high whenever state ≠ IDLE.
- TxErrTimeout  out  1  one-cycle pulse when a burst is truncated; constant 0 without HS_TX_TIMEOUT_EN.

## Operation
- **States:** IDLE, REQ, PREP, ZERO, SYNC, DATA, TRAIL, EXIT.
- **State counter:** one down-counter, loaded on each state entry, sized for the largest T_* parameter.
- **IDLE**
  - Outputs: LpDrive=2'b11, HsEn=0, TxByteHS=0, TxReadyHS=0.
  - Moves to REQ when TxRequestHS=1.
- **REQ:** LpDrive=2'b01 for T_LPX cycles, then PREP.
- **PREP:** LpDrive=2'b00 for T_PREP cycles, then ZERO.
- **ZERO:** LpDrive=00, HsEn=1, TxByteHS=0x00 for T_ZERO cycles, then SYNC.
- **SYNC:** one cycle, TxByteHS=SYNC, TxReadyHS=1.
  - Byte accepted → DATA.
  - No byte accepted → TRAIL (zero-length burst).
- **DATA:** TxReadyHS=1.
  - Each accepted byte drives TxByteHS on the following cycle.
  - The first edge where TxRequestHS=0 → TRAIL, and TxReadyHS falls on that edge.
- **TRAIL:** TxByteHS = all bits equal to ~last_bit for T_TRAIL cycles.
  - last_bit is bit W-1 of the last byte sent, because bit W-1 is the last bit serialized.
  - The last byte is SYNC for a zero-length burst.
  - Then EXIT.
- **EXIT:** HsEn=0, LpDrive=11, TxByteHS=0 for T_EXIT cycles, then IDLE.
- **Boundary cases:**
  - TxRequestHS falls during REQ/PREP/ZERO: no abort; the sequence completes through SYNC → TRAIL.
  - TxRequestHS high during EXIT: ignored. A new burst starts only from IDLE.
  - Tx_RST asserted in any state: IDLE outputs immediately, with no trailer.

## Timing
- **Reset values:** TxByteHS=0, HsEn=0, LpDrive=2'b11, TxReadyHS=0, Busy=0, TxErrTimeout=0.
- **Cycle numbering:** TxRequestHS is sampled high in IDLE at edge 0. With default parameters:
  - REQ: cycles 1–2
  - PREP: cycles 3–6
  - ZERO: cycles 7–12, with HsEn rising at cycle 7
  - SYNC: cycle 13
  - First payload on TxByteHS: cycle 14
- **Throughput:** one byte per cycle. There is no backpressure inside DATA.
- **Trailer:** begins on the cycle after the last payload byte. HsEn falls T_TRAIL cycles later.
- **Back-to-back:** minimum idle gap between bursts is 1 IDLE cycle.

## Configuration
- **Macro:** HS_TX_TIMEOUT_EN
- **Defined:**
  - A payload counter counts accepted bytes and clears in IDLE.
  - When byte MAX_BURST is accepted, TxReadyHS falls on that same edge and the next state is TRAIL.
  - TxErrTimeout pulses for 1 cycle on the first TRAIL cycle.
- **Undefined:**
  - No counter is built; bursts are unbounded.
  - TxErrTimeout is tied to 0.

## Test plan
- **Reset:** Tx_RST=0 → all outputs at reset values. Release reset with TxRequestHS=0 → block stays in IDLE, LpDrive=11.
- **Single byte:** TxRequestHS held for one accept with TxDataHS=8'hAB → LpDrive 01(2 cycles), 00(4 cycles); TxByteHS 0x00×6, 0xB8, 0xAB, then 0x00×4 (bit7 of 0xAB is 1); then HsEn=0, LpDrive=11×3, then IDLE.
- **Multi-byte:** 4 bytes 0x01,0x02,0x03,0x7F → bytes appear on consecutive cycles 14–17; trailer 0xFF×4 (bit7 of 0x7F is 0).
- **Zero-length and late drop:** TxRequestHS falls at cycle 4 → sync sent, TxReadyHS high only at cycle 13, trailer 0x00×4 (bit7 of 0xB8 is 1).
- **Reset mid-DATA:** Tx_RST asserted → HsEn=0 and LpDrive=11 immediately, with no trailer; next request runs a full sequence.
- **Timeout (HS_TX_TIMEOUT_EN, MAX_BURST=3):** continuous request → exactly 3 payload bytes, TxErrTimeout high for one cycle at trailer start. Without the macro the same stimulus sends all bytes and TxErrTimeout stays 0.
